// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared constants and elaboration helpers for the single-clock
//               FIFO. No ports; imported by sync_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    // Default geometry of the FIFO.
    localparam int c_DEFAULT_DEPTH      = 16;
    localparam int c_DEFAULT_DATA_WIDTH = 10;

    // True when n is a non-zero power of two. Used at elaboration time to
    // reject depths that would break the wrap-bit pointer scheme.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : sync_fifo_pkg

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_WIDTH storage array with a synchronous write port
//               and a registered read port. Only the read register is reset;
//               the array contents are left untouched by reset.
// Ports       : clk_i    - clock, rising edge
//               rst_i    - synchronous active-high reset (read register only)
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable; read register loads when high
//               raddr_i  - read address
//               rdata_o  - registered read data, holds when re_i is low
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array: no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: reads the array as it stood before this edge, so a
    // write and read to the same address in one cycle never forwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sync_fifo_mem

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock synchronous FIFO with full/empty status and
//               one-cycle overflow/underflow error pulses. Read latency is
//               one clock; ordering is strictly first-in first-out.
// Ports       : clk_i       - clock, rising edge
//               rst_i       - synchronous active-high reset
//               wr_en_i     - write request
//               wdata_i     - write data
//               full_o      - FIFO holds DEPTH entries
//               overflow_o  - write attempted while full (registered)
//               rd_en_i     - read request
//               rdata_o     - read data, valid after the accepting edge
//               empty_o     - FIFO holds 0 entries
//               underflow_o - read attempted while empty (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  overflow_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  underflow_o
);

    // Address width is derived from DEPTH and never overridden.
    localparam int PTR_WIDTH = $clog2(DEPTH);

    localparam logic [PTR_WIDTH:0] c_PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Elaboration-time geometry check
    // ------------------------------------------------------------------
    generate
        if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointer and flag state
    // ------------------------------------------------------------------
    // Pointers carry one extra MSB that toggles on every wrap. Equal
    // pointers mean empty; equal low bits with differing MSBs mean full.
    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                     (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

    // Acceptance uses the flags as they stand before the edge, so a
    // simultaneous read does not make room for a write at full, and a
    // simultaneous write does not supply data to a read at empty.
    assign w_wr_accept = wr_en_i & ~w_full;
    assign w_rd_accept = rd_en_i & ~w_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = wr_en_i & w_full;
        underflow_d = rd_en_i & w_empty;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd_accept) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic w_mem_we;
    logic w_mem_re;

    // Writes are suppressed during reset so a discarded word cannot land
    // in the array behind the freshly cleared pointers.
    assign w_mem_we = w_wr_accept & ~rst_i;
    assign w_mem_re = w_rd_accept;

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_mem_we),
        .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata_i (wdata_i),
        .re_i    (w_mem_re),
        .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_o (rdata_o)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule : sync_fifo

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. A queue model holds the
//               expected contents; expected read data is popped from it when
//               a read is driven and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    localparam int DEPTH      = 16;
    localparam int DATA_WIDTH = 10;

    logic                  clk;
    logic                  rst;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  empty;
    logic                  underflow;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wdata_i     (wdata),
        .full_o      (full),
        .overflow_o  (overflow),
        .rd_en_i     (rd_en),
        .rdata_o     (rdata),
        .empty_o     (empty),
        .underflow_o (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    // Model state
    logic [DATA_WIDTH-1:0] model_q[$];
    logic [DATA_WIDTH-1:0] exp_rdata;
    logic                  exp_ovf;
    logic                  exp_udf;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rdata"},     32'(rdata),     32'(exp_rdata));
        check({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
    endtask

    // One clock with the given request pattern; the model decides acceptance
    // from its occupancy before the edge.
    task automatic step(input string tag, input logic wr,
                        input logic [DATA_WIDTH-1:0] wd, input logic rd);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        wr_en = wr;
        wdata = wd;
        rd_en = rd;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        exp_ovf   = wr && was_full;
        exp_udf   = rd && was_empty;
        if (rd && !was_empty) exp_rdata = model_q.pop_front();
        if (wr && !was_full)  model_q.push_back(wd);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input int cycles, input logic wr, input logic rd);
        @(negedge clk);
        rst   = 1'b1;
        wr_en = wr;
        rd_en = rd;
        wdata = 10'h3FF;
        repeat (cycles) @(posedge clk);
        #1;
        model_q.delete();
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        check_outputs("reset");
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wdata     = '0;
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;

        // Reset, then idle
        do_reset(2, 1'b0, 1'b0);
        step("idle", 1'b0, '0, 1'b0);

        // Two words in, two out
        step("w1", 1'b1, 10'h001, 1'b0);
        step("w2", 1'b1, 10'h002, 1'b0);
        for (int i = 0; i < 2; i++) step("r2", 1'b0, '0, 1'b1);

        // Five in, six reads: last read underflows, data holds 0x015
        for (int i = 0; i < 5; i++) step("w5", 1'b1, 10'(10'h011 + i), 1'b0);
        for (int i = 0; i < 6; i++) step("r6", 1'b0, '0, 1'b1);
        step("hold", 1'b0, '0, 1'b0);

        // 21 writes: full after 16, five overflow cycles; then drain
        for (int i = 0; i < 21; i++) step("w21", 1'b1, 10'(10'h100 + i), 1'b0);
        for (int i = 0; i < 16; i++) step("r16", 1'b0, '0, 1'b1);

        // Fill, drain with rd_en held 22 cycles, refill across the wrap
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 10'(10'h200 + i), 1'b0);
        for (int i = 0; i < 22; i++) step("r22", 1'b0, '0, 1'b1);
        for (int i = 0; i < 12; i++) step("refill", 1'b1, 10'(10'h2A0 + i), 1'b0);
        for (int i = 0; i < 12; i++) step("rdback", 1'b0, '0, 1'b1);

        // Simultaneous write and read at occupancy 8
        for (int i = 0; i < 8; i++) step("w8", 1'b1, 10'(10'h300 + i), 1'b0);
        for (int i = 0; i < 10; i++) step("wr_rd", 1'b1, 10'(10'h340 + i), 1'b1);

        // Both at empty and both at full
        do_reset(1, 1'b1, 1'b1);
        step("both_empty", 1'b1, 10'h155, 1'b1);
        for (int i = 0; i < 15; i++) step("fill2", 1'b1, 10'(10'h160 + i), 1'b0);
        step("both_full", 1'b1, 10'h1EE, 1'b1);
        step("rd_one", 1'b0, '0, 1'b1);

        // Reset mid-stream with requests active
        do_reset(1, 1'b1, 1'b1);
        step("post_rst", 1'b0, '0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule : tb_sync_fifo

`default_nettype wire
